// File: rtl/pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_flow_ctrl
// Description : Applies hazard-unit stall/flush requests to a 5-stage pipeline:
//               stage valid bits, PC enable, stall watchdog, perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_flow_ctrl #(
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic             if_dr_en,
    input  logic             id_ex_en,
    input  logic             if_dr_clear,
    input  logic             id_ex_clear,
    output logic             pc_en,
    output logic             if_dr_valid,
    output logic             id_ex_valid,
    output logic             ex_mem_valid,
    output logic             mem_wb_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             wdog_trip
);

    localparam int                  c_wdog_w     = $clog2(WDOG_LIMIT + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_limit = c_wdog_w'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0]    c_cnt_max    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALLED = 2'd1,
        TRIPPED = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_wdog_w-1:0] r_wdog_cnt;
    logic [c_wdog_w-1:0] w_wdog_cnt_nxt;
    logic                w_trip_set;

    logic w_hold;
    logic w_flush;
    logic w_stall;

    logic             r_if_dr_valid;
    logic             r_id_ex_valid;
    logic             r_ex_mem_valid;
    logic             r_mem_wb_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_retire_cnt;
    logic             r_wdog_trip;

    assign w_hold  = ~if_dr_en | ~id_ex_en;
    assign w_flush = if_dr_clear | id_ex_clear;
    assign w_stall = w_hold & ~w_flush;

    // A flush redirects the PC even while the front end is held.
    assign pc_en = ~w_hold | w_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_dr_valid  <= 1'b0;
            r_id_ex_valid  <= 1'b0;
            r_ex_mem_valid <= 1'b0;
            r_mem_wb_valid <= 1'b0;
        end else begin
            r_if_dr_valid  <= if_dr_clear ? 1'b0 : (w_hold ? r_if_dr_valid : fetch_valid);
            r_id_ex_valid  <= id_ex_clear ? 1'b0 : (w_hold ? 1'b0 : r_if_dr_valid);
            r_ex_mem_valid <= r_id_ex_valid;
            r_mem_wb_valid <= r_ex_mem_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (r_mem_wb_valid && (r_retire_cnt != c_cnt_max)) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wdog_cnt <= w_wdog_cnt_nxt;
            if (w_trip_set) begin
                r_wdog_trip <= 1'b1;
            end
        end
    end

    // The count reaches WDOG_LIMIT on the WDOG_LIMIT-th consecutive stalled edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_wdog_cnt_nxt = r_wdog_cnt;
        w_trip_set     = 1'b0;
        case (r_state)
            RUN: begin
                if (w_stall) begin
                    w_state_nxt    = STALLED;
                    w_wdog_cnt_nxt = c_wdog_w'(1);
                end
            end
            STALLED: begin
                if (w_stall) begin
                    w_wdog_cnt_nxt = r_wdog_cnt + c_wdog_w'(1);
                    if (w_wdog_cnt_nxt == c_wdog_limit) begin
                        w_state_nxt = TRIPPED;
                        w_trip_set  = 1'b1;
                    end
                end else begin
                    w_state_nxt    = RUN;
                    w_wdog_cnt_nxt = '0;
                end
            end
            TRIPPED: begin
                if (!w_stall) begin
                    w_state_nxt    = RUN;
                    w_wdog_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wdog_cnt_nxt = '0;
            end
        endcase
    end

    assign if_dr_valid  = r_if_dr_valid;
    assign id_ex_valid  = r_id_ex_valid;
    assign ex_mem_valid = r_ex_mem_valid;
    assign mem_wb_valid = r_mem_wb_valid;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign retire_cnt   = r_retire_cnt;
    assign wdog_trip    = r_wdog_trip;

endmodule
`default_nettype wire

// File: tb/tb_pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_flow_ctrl
// Description : Self-checking bench for pipe_flow_ctrl against a stage-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_flow_ctrl;

    localparam int CNT_W      = 4;
    localparam int WDOG_LIMIT = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             fetch_valid;
    logic             if_dr_en;
    logic             id_ex_en;
    logic             if_dr_clear;
    logic             id_ex_clear;
    logic             pc_en;
    logic             if_dr_valid;
    logic             id_ex_valid;
    logic             ex_mem_valid;
    logic             mem_wb_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;
    logic             wdog_trip;

    pipe_flow_ctrl #(
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fetch_valid),
        .if_dr_en     (if_dr_en),
        .id_ex_en     (id_ex_en),
        .if_dr_clear  (if_dr_clear),
        .id_ex_clear  (id_ex_clear),
        .pc_en        (pc_en),
        .if_dr_valid  (if_dr_valid),
        .id_ex_valid  (id_ex_valid),
        .ex_mem_valid (ex_mem_valid),
        .mem_wb_valid (mem_wb_valid),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .retire_cnt   (retire_cnt),
        .wdog_trip    (wdog_trip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stage occupancy list, plain integer counters, stall run length.
    int m_v[4];
    int m_stall;
    int m_flush;
    int m_retire;
    int m_run;
    int m_trip;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_reset();
        foreach (m_v[i]) m_v[i] = 0;
        m_stall  = 0;
        m_flush  = 0;
        m_retire = 0;
        m_run    = 0;
        m_trip   = 0;
    endtask

    task automatic check_state(input string where);
        check({where, ".if_dr_valid"},  int'(if_dr_valid),  m_v[0]);
        check({where, ".id_ex_valid"},  int'(id_ex_valid),  m_v[1]);
        check({where, ".ex_mem_valid"}, int'(ex_mem_valid), m_v[2]);
        check({where, ".mem_wb_valid"}, int'(mem_wb_valid), m_v[3]);
        check({where, ".stall_cnt"},    int'(stall_cnt),    m_stall);
        check({where, ".flush_cnt"},    int'(flush_cnt),    m_flush);
        check({where, ".retire_cnt"},   int'(retire_cnt),   m_retire);
        check({where, ".wdog_trip"},    int'(wdog_trip),    m_trip);
    endtask

    // Called just after a negedge: drive, check pc_en, take the edge, check state.
    task automatic step(input bit fv, input bit ie, input bit de, input bit ic, input bit dc);
        bit hold, flush, stall;
        int nv0, nv1;
        fetch_valid = fv;
        if_dr_en    = ie;
        id_ex_en    = de;
        if_dr_clear = ic;
        id_ex_clear = dc;
        hold  = !ie || !de;
        flush = ic || dc;
        stall = hold && !flush;
        #1;
        check("pc_en", int'(pc_en), int'(!hold || flush));
        @(posedge clk);
        if (stall) m_stall = sat_inc(m_stall);
        if (flush) m_flush = sat_inc(m_flush);
        if (m_v[3] != 0) m_retire = sat_inc(m_retire);
        nv0 = ic ? 0 : (hold ? m_v[0] : int'(fv));
        nv1 = dc ? 0 : (hold ? 0 : m_v[0]);
        m_v[3] = m_v[2];
        m_v[2] = m_v[1];
        m_v[1] = nv1;
        m_v[0] = nv0;
        m_run = stall ? m_run + 1 : 0;
        if (m_run >= WDOG_LIMIT) m_trip = 1;
        #1;
        check_state("edge");
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle; state must clear with no clock edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        fetch_valid = 1'b0;
        if_dr_en    = 1'b1;
        id_ex_en    = 1'b1;
        if_dr_clear = 1'b0;
        id_ex_clear = 1'b0;
        model_reset();
        #12;
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Steady fill, no hazards
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0);
        check("fill.retire_cnt_6", int'(retire_cnt), 6);

        // RAW stall for two cycles
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("raw.stall_cnt_2", int'(stall_cnt), 2);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);

        // Branch taken, then flush during hold
        step(1, 1, 1, 1, 1);
        check("branch.if_dr_valid", int'(if_dr_valid), 0);
        check("branch.id_ex_valid", int'(id_ex_valid), 0);
        step(1, 1, 0, 1, 0);
        check("flush_hold.if_dr_valid", int'(if_dr_valid), 0);
        check("flush_hold.stall_cnt", int'(stall_cnt), 2);

        // Watchdog: five stalled cycles trip, and the trip stays sticky
        async_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        check("wdog.not_yet", int'(wdog_trip), 0);
        step(1, 1, 0, 0, 0);
        check("wdog.tripped", int'(wdog_trip), 1);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        check("wdog.sticky", int'(wdog_trip), 1);

        // Saturation of retire_cnt
        async_reset();
        for (int i = 0; i < 24; i++) step(1, 1, 1, 0, 0);
        check("sat.retire_cnt", int'(retire_cnt), CNT_MAX);

        // Randomized hazard mix with occasional mid-run resets
        for (int i = 0; i < 600; i++) begin
            bit fv, ie, de, ic, dc;
            fv = ($urandom_range(0, 9) < 8);
            ie = ($urandom_range(0, 9) < 8);
            de = ($urandom_range(0, 9) < 7);
            ic = ($urandom_range(0, 9) < 1);
            dc = ($urandom_range(0, 9) < 1);
            step(fv, ie, de, ic, dc);
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
Consumes the stall/flush requests produced by the hazard unit (if_dr_en, id_ex_en, if_dr_clear, id_ex_clear) and applies them to the 5-stage pipeline. It owns the per-stage valid bits, the PC enable, bubble insertion, and a stall watchdog. It also keeps saturating performance counters. It sits between the hazard unit and the pipeline registers, which use its valid outputs to qualify their writes.

Parameters:
CNT_W, 32, width of each performance counter
WDOG_LIMIT, 16, number of consecutive stall cycles that trips the watchdog (minimum 2)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
fetch_valid  input  1  instruction memory presents a valid instruction this cycle
if_dr_en  input  1  hazard unit: IF/ID register may load
id_ex_en  input  1  hazard unit: ID/EX register may load
if_dr_clear  input  1  hazard unit: flush IF/ID
id_ex_clear  input  1  hazard unit: flush ID/EX
pc_en  output  1  PC register update enable (combinational)
if_dr_valid  output  1  IF/ID holds a live instruction
id_ex_valid  output  1  ID/EX holds a live instruction
ex_mem_valid  output  1  EX/MEM holds a live instruction
mem_wb_valid  output  1  MEM/WB holds a live instruction (retiring)
stall_cnt  output  CNT_W  cycles spent stalled
flush_cnt  output  CNT_W  cycles with any flush asserted
retire_cnt  output  CNT_W  instructions retired
wdog_trip  output  1  sticky; the stall persisted for WDOG_LIMIT cycles

Behaviour:
- Definitions: hold = ~if_dr_en | ~id_ex_en; flush = if_dr_clear | id_ex_clear; stall = hold & ~flush.
- Reset, asynchronous: all valid bits 0, all counters 0, wdog_trip 0, watchdog count 0, FSM in RUN.
- pc_en = ~hold | flush. A flush always lets the PC take the redirect, even while hold is asserted.
- The valid bits update on the rising clk edge, 1-cycle latency:
  - if_dr_valid <= if_dr_clear ? 0 : (hold ? if_dr_valid : fetch_valid)
  - id_ex_valid <= id_ex_clear ? 0 : (hold ? 0 : if_dr_valid). A hold inserts a bubble.
  - ex_mem_valid <= id_ex_valid; mem_wb_valid <= ex_mem_valid. The back stages never stall.
- Priority: clear beats hold for the same stage. Simultaneous if_dr_clear and id_ex_clear zero both front stages in the same edge.
- FSM (state is internal and not exported):
  - RUN: stall -> STALLED (wdog count = 1); otherwise stay.
  - STALLED: stall -> count++, and at count == WDOG_LIMIT -> TRIPPED with wdog_trip set. ~stall -> RUN with count = 0.
  - TRIPPED: wdog_trip stays at 1 until rst. The pipeline keeps following the valid rules above. Returns to RUN (count = 0) when ~stall, but wdog_trip stays set.
  - A flush during STALLED returns to RUN and zeroes the count.
- Counters (all saturate at 2^CNT_W-1 and never wrap):
  - stall_cnt +1 on every cycle with stall.
  - flush_cnt +1 on every cycle with flush.
  - retire_cnt +1 on every cycle with mem_wb_valid.
- Reset mid-operation: all state clears immediately with no clock needed. The first fetch after rst deasserts enters IF/ID on the next edge.
- fetch_valid=0 with no hold: if_dr_valid becomes 0 and a bubble propagates normally.

Test Plan:
- Reset release, fetch_valid=1, no hazards, 10 cycles -> valid bits fill in order IF/ID, ID/EX, EX/MEM, MEM/WB at cycles 1-4; retire_cnt=6 after cycle 10; pc_en=1 throughout.
- RAW stall: id_ex_en=0 for 2 cycles during steady flow -> if_dr_valid held at 1; two id_ex_valid=0 bubbles reach mem_wb_valid 3 cycles later; stall_cnt=2; pc_en=0 for those 2 cycles.
- Branch taken: if_dr_clear=id_ex_clear=1 for 1 cycle -> if_dr_valid=0 and id_ex_valid=0 next cycle; flush_cnt=1; pc_en=1 that cycle.
- Flush during hold: id_ex_en=0 with if_dr_clear=1 -> if_dr_valid=0 (clear wins); pc_en=1; stall_cnt unchanged; flush_cnt +1.
- Watchdog with WDOG_LIMIT=4: id_ex_en=0 for 5 cycles -> wdog_trip=1 after 4th stalled edge; stays 1 after the stall ends; clears only on rst.
- Saturation with CNT_W=4: 20 retiring cycles -> retire_cnt=15 and holds; async rst pulse mid-run -> all outputs 0 before the next clk edge.
